// File: rtl/apb_pkg.sv
// Shared APB definitions used by the master/arbiter and the existing APB slave.
// Contents:
//   APB_ADDR_W / APB_DATA_W  default bus widths
//   apb_state_t              APB protocol phase (IDLE, SETUP, ACCESS)
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. It grants the first requesting bit found
// when scanning cyclically upward from ptr (ptr itself is checked first).
// The pointer register is owned by the instantiating block.
// Ports:
//   req      in  N   request vector
//   ptr      in  IW  index of highest-priority requester
//   gnt      out N   one-hot grant (all zero when req is zero)
//   gnt_idx  out IW  binary index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr is always < N, so the modulo keeps idx inside the request vector
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB bus between NUM_REQ local requesters and drives it as the
// APB master. One transfer at a time, round-robin between requesters, with a
// bounded wait-state timeout so a stalled slave cannot hang the bus.
//
// Requester handshake: a requester raises req_valid[i] with req_write/addr/wdata
// and keeps req_valid[i] high until it sees req_done[i]. The fields are captured
// at grant, so later changes (including dropping req_valid) do not affect a
// transfer already granted. req_done is a one-cycle pulse; rsp_rdata and rsp_err
// are meaningful only in that cycle. No new grant is made in the req_done cycle,
// which gives the requester one cycle to lower req_valid.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/write       per-requester request and direction
//   req_addr/req_wdata    packed per-requester address / write data
//   req_done              one-hot completion pulse
//   rsp_rdata, rsp_err    completion read data and error (pslverr or timeout)
//   paddr..pwdata         APB master outputs
//   prdata,pready,pslverr APB slave responses
//   dbg_state             current APB phase, for observation only
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output apb_state_t                dbg_state
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

  apb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic [WAIT_W-1:0]    wait_inc;
  logic [IDX_W-1:0]     next_ptr;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_oh_d = gnt_oh_q;
    wait_d   = wait_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    done_d   = '0;
    rdata_d  = '0;
    err_d    = 1'b0;
    // saturating increment: the counter never wraps back to zero
    wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    next_ptr = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        // done_q high means this is the turnaround cycle: hold off arbitration
        if ((|req_valid) && (done_q == '0)) begin
          state_d  = SETUP;
          gnt_d    = arb_idx;
          gnt_oh_d = arb_gnt;
          paddr_d  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          pwrite_d = req_write[arb_idx];
          pwdata_d = req_write[arb_idx] ? req_wdata[int'(arb_idx)*DATA_W +: DATA_W] : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d = IDLE;
          done_d  = gnt_oh_q;
          rdata_d = pwrite_q ? '0 : prdata;
          err_d   = pslverr;
          ptr_d   = next_ptr;
        end else begin
          wait_d = wait_inc;
          if ((TIMEOUT_CYCLES != 0) && (wait_inc == WAIT_LIM)) begin
            state_d = IDLE;
            done_d  = gnt_oh_q;
            err_d   = 1'b1;
            ptr_d   = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_oh_q  <= '0;
      wait_q    <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_oh_q  <= gnt_oh_d;
      wait_q    <= wait_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign paddr     = paddr_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter with a small behavioural APB slave whose
// wait states are set per transfer. Addresses at or above 0x100 answer with
// pslverr and read data 0xE0E0E0E0.
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam int NR  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_done;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic [AW-1:0]    paddr;
  logic             psel, penable, pwrite;
  logic [DW-1:0]    pwdata, prdata;
  logic             pready, pslverr;
  apb_state_t       dbg_state;

  apb_master_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .dbg_state(dbg_state)
  );

  // ---------------- APB slave model ----------------
  logic [31:0] mem [16];
  int          wait_cfg = 0;
  int          acc_cnt  = 0;
  logic        bad_addr;

  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;

  assign bad_addr = (paddr[31:8] != 24'h0);
  assign pready   = (acc_cnt >= wait_cfg);
  assign pslverr  = psel && penable && bad_addr;
  assign prdata   = bad_addr ? 32'hE0E0E0E0 : mem[paddr[5:2]];

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready && pwrite && !bad_addr) mem[paddr[5:2]] <= pwdata;
  end

  // ---------------- checking ----------------
  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // scoreboard entry: {req_done one-hot, rsp_err, rsp_rdata}
  logic [34:0] exp_q[$];
  logic [34:0] sb_e;

  always @(negedge clk) begin
    if (rst_n && req_done != '0) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 64'(req_done), 64'(0));
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_done",  64'(req_done),  64'(sb_e[34:33]));
        check("sb_rdata", 64'(rsp_rdata), 64'(sb_e[31:0]));
        check("sb_err",   64'(rsp_err),   64'(sb_e[32]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(int r, logic w, logic [31:0] a, logic [31:0] d);
    req_write[r]          = w;
    req_addr[r*AW +: AW]  = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  task automatic push_exp(int r, logic [31:0] rd, logic er);
    logic [1:0] oh;
    oh = 2'(1 << r);
    exp_q.push_back({oh, er, rd});
  endtask

  // waits for req_done[r]; lat counts negedges from the call
  task automatic wait_done(int r, int maxc, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!req_done[r] && lat < maxc);
    if (!req_done[r]) begin
      check_cnt++;
      $display("FAIL wait_done: no req_done[%0d] within %0d cycles", r, maxc);
    end
  endtask

  task automatic wait_any(int maxc, output int g);
    int n;
    n = 0;
    g = -1;
    do begin
      @(negedge clk);
      n++;
    end while (req_done == '0 && n < maxc);
    if (req_done == '0) begin
      check_cnt++;
      $display("FAIL wait_any: no req_done within %0d cycles", maxc);
    end else begin
      g = req_done[1] ? 1 : 0;
    end
  endtask

  // Single-requester transfer starting from a clean IDLE cycle (called at a negedge).
  task automatic do_xfer(int r, logic w, logic [31:0] a, logic [31:0] d, int waits,
                         logic [31:0] er, logic ee, int exp_lat);
    int          lat;
    logic        stable;
    logic [31:0] exp_wd;
    exp_wd   = w ? d : 32'h0;
    wait_cfg = waits;
    set_req(r, w, a, d);
    push_exp(r, er, ee);
    req_valid[r] = 1'b1;
    @(negedge clk);
    lat = 1;
    check("setup_phase", 64'({psel, penable}), 64'(2'b10));
    check("setup_paddr", 64'(paddr), 64'(a));
    check("setup_pwrite", 64'(pwrite), 64'(w));
    check("setup_pwdata", 64'(pwdata), 64'(exp_wd));
    stable = 1'b1;
    while (!req_done[r] && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!req_done[r] && !(psel && penable && paddr == a && pwrite == w && pwdata == exp_wd))
        stable = 1'b0;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("access_stable", 64'(stable), 64'(1));
    req_valid[r] = 1'b0;
    @(negedge clk);
    check("idle_after_done", 64'({psel, penable}), 64'(0));
    check("paddr_hold_idle", 64'(paddr), 64'(a));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          waits;
    logic [31:0] er;
    logic        ee;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  initial begin : main
    int          lat;
    int          g;
    int          pc;
    int          rr;
    logic [31:0] rd;
    logic [31:0] ra;

    tbl[0] = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 0,   32'h0,        1'b0, 3};
    tbl[1] = '{0, 1'b0, 32'h10,  32'hFFFF0000, 0,   32'hDEADBEEF, 1'b0, 3};
    tbl[2] = '{1, 1'b1, 32'h14,  32'h12345678, 2,   32'h0,        1'b0, 5};
    tbl[3] = '{1, 1'b0, 32'h14,  32'h0F0F0F0F, 1,   32'h12345678, 1'b0, 4};
    tbl[4] = '{0, 1'b1, 32'h200, 32'h11112222, 0,   32'h0,        1'b1, 3};
    tbl[5] = '{1, 1'b0, 32'h300, 32'h33334444, 0,   32'hE0E0E0E0, 1'b1, 3};
    tbl[6] = '{0, 1'b0, 32'h10,  32'h0,        3,   32'hDEADBEEF, 1'b0, 6};
    tbl[7] = '{1, 1'b0, 32'h10,  32'h0,        100, 32'h0,        1'b1, 18};
    tbl[8] = '{1, 1'b1, 32'h18,  32'hCAFEF00D, 0,   32'h0,        1'b0, 3};
    tbl[9] = '{0, 1'b0, 32'h18,  32'h5A5A5A5A, 0,   32'hCAFEF00D, 1'b0, 3};

    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_psel_penable", 64'({psel, penable}), 64'(0));
    check("rst_req_done", 64'(req_done), 64'(0));
    check("rst_paddr", 64'(paddr), 64'(0));
    check("rst_pwdata", 64'(pwdata), 64'(0));
    check("rst_rsp", 64'({rsp_err, rsp_rdata}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven single transfers
    for (int i = 0; i < 10; i++)
      do_xfer(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].waits, tbl[i].er, tbl[i].ee, tbl[i].lat);

    // random write/readback pairs
    for (int i = 0; i < 4; i++) begin
      rr = $urandom_range(0, 1);
      rd = $urandom;
      ra = 32'h30 + 32'(4 * i);
      g  = $urandom_range(0, 3);
      do_xfer(rr, 1'b1, ra, rd, g, 32'h0, 1'b0, 3 + g);
      do_xfer(1 - rr, 1'b0, ra, 32'hFFFFFFFF, 0, rd, 1'b0, 3);
    end
    // last transfer above may leave ptr anywhere; pin it with a req1 transfer (ptr -> 0)
    do_xfer(1, 1'b0, 32'h18, 32'h0, 0, 32'hCAFEF00D, 1'b0, 3);

    // req_valid[0] dropped during SETUP; req1 raised while req0 is in flight
    wait_cfg = 0;
    set_req(0, 1'b1, 32'h1C, 32'h55AA55AA);
    push_exp(0, 32'h0, 1'b0);
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("drop_setup_phase", 64'({psel, penable}), 64'(2'b10));
    req_valid[0] = 1'b0;
    set_req(1, 1'b0, 32'h1C, 32'h0);
    push_exp(1, 32'h55AA55AA, 1'b0);
    req_valid[1] = 1'b1;
    wait_done(0, 10, lat);
    check("drop_latency", 64'(lat), 64'(2));
    @(negedge clk);
    check("no_grant_turnaround", 64'(psel), 64'(0));
    wait_done(1, 10, lat);
    check("after_drop_latency", 64'(lat), 64'(3));
    req_valid[1] = 1'b0;
    @(negedge clk);

    // both requesters held continuously: alternating grants, 4 cycles apart
    wait_cfg = 0;
    set_req(0, 1'b1, 32'h20, 32'hA0A0A0A0);
    set_req(1, 1'b1, 32'h24, 32'hB1B1B1B1);
    push_exp(0, 32'h0, 1'b0);
    push_exp(1, 32'h0, 1'b0);
    push_exp(0, 32'h0, 1'b0);
    push_exp(1, 32'h0, 1'b0);
    req_valid = 2'b11;
    pc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any(12, g);
      check("rr_grant", 64'(g), 64'(k % 2));
      if (k > 0) check("rr_gap", 64'(cyc - pc), 64'(4));
      pc = cyc;
      if (k == 3) req_valid = 2'b00;
    end
    repeat (2) @(negedge clk);
    check("rr_no_extra_grant", 64'(psel), 64'(0));

    // reset during ACCESS: ptr is made nonzero first, then the transfer is dropped
    do_xfer(0, 1'b1, 32'h28, 32'h77778888, 0, 32'h0, 1'b0, 3);
    wait_cfg = 100;
    set_req(1, 1'b1, 32'h2C, 32'h99990000);
    req_valid[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_access", 64'(dbg_state), 64'(ACCESS));
    rst_n = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    check("mid_reset_psel_penable", 64'({psel, penable}), 64'(0));
    check("mid_reset_done", 64'(req_done), 64'(0));
    check("mid_reset_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    wait_cfg = 0;
    set_req(0, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b0, 32'h24, 32'h0);
    push_exp(0, 32'hA0A0A0A0, 1'b0);
    push_exp(1, 32'hB1B1B1B1, 1'b0);
    req_valid = 2'b11;
    wait_any(12, g);
    check("post_reset_ptr0", 64'(g), 64'(0));
    req_valid[0] = 1'b0;
    wait_done(1, 10, lat);
    check("post_reset_req1_gap", 64'(lat), 64'(4));
    req_valid[1] = 1'b0;
    check("aborted_write_not_done", 64'(mem[11]), 64'(0));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
